// File: rtl/vliw_bundle_packer.sv
// Packs a stream of scalar 32-bit instructions into 4-slot 128-bit VLIW bundles.
// A bundle closes on full, on an intra-bundle RAW/WAW hazard, or on flush. Defining
// BUNDLE_TIMEOUT_EN adds an idle timeout (TIMEOUT_CYC) that closes partial bundles.
module vliw_bundle_packer (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_instr,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] vliw_instr,
  output logic         illegal,
  output logic [15:0]  bundle_cnt
);
  localparam int unsigned SLOTS = 4;
  localparam int unsigned IW    = 32;
  localparam int unsigned CW    = 3;
  localparam int unsigned BW    = 16;

  logic [SLOTS-1:0][IW-1:0] acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [SLOTS*IW-1:0]      ob_q, ob_d;
  logic                     out_valid_q, out_valid_d;
  logic                     flush_pend_q, flush_pend_d;
  logic                     illegal_q, illegal_d;
  logic [BW-1:0]            bundle_cnt_q, bundle_cnt_d;

  logic [2:0] op_c, dest_c, src1_c, src2_c;
  logic       rd1_c, rd2_c, op_ok_c, word_legal_c, word_illegal_c, cnt_nz_c;
  logic       hazard_c, close_c, ob_free_c, accept_c, do_close_c, timeout_c;

  // Field decode of the incoming word
  assign op_c           = in_instr[2:0];
  assign dest_c         = in_instr[5:3];
  assign src1_c         = in_instr[8:6];
  assign src2_c         = in_instr[11:9];
  assign op_ok_c        = (op_c == 3'b000) || (op_c == 3'b001) ||
                          (op_c == 3'b010) || (op_c == 3'b100);
  assign rd1_c          = (op_c != 3'b100);
  assign rd2_c          = (op_c == 3'b000) || (op_c == 3'b001);
  assign word_legal_c   = in_instr[31] && op_ok_c;
  assign word_illegal_c = in_instr[31] && !op_ok_c;
  assign cnt_nz_c       = (cnt_q != '0);

  // WAW against any filled dest, RAW against the sources this op actually reads
  always_comb begin
    hazard_c = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (CW'(i) < cnt_q) begin
        if ((acc_q[i][5:3] == dest_c) ||
            (rd1_c && (acc_q[i][5:3] == src1_c)) ||
            (rd2_c && (acc_q[i][5:3] == src2_c))) begin
          hazard_c = 1'b1;
        end
      end
    end
  end

  // A flush seen this cycle closes immediately; otherwise it waits in flush_pend_q
  assign close_c    = (cnt_q == CW'(SLOTS)) ||
                      (cnt_nz_c && in_valid && word_legal_c && hazard_c) ||
                      (cnt_nz_c && (flush_pend_q || flush)) ||
                      timeout_c;
  assign ob_free_c  = !out_valid_q || out_ready;
  assign in_ready   = close_c ? ob_free_c : (cnt_q < CW'(SLOTS));
  assign accept_c   = in_valid && in_ready;
  assign do_close_c = close_c && ob_free_c;

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ob_d         = ob_q;
    out_valid_d  = out_valid_q && !out_ready;
    flush_pend_d = flush_pend_q || (flush && cnt_nz_c);
    illegal_d    = accept_c && word_illegal_c;
    bundle_cnt_d = bundle_cnt_q;
    if (do_close_c) begin
      // Unused slots are already zero, so they leave as NOPs
      ob_d         = acc_q;
      out_valid_d  = 1'b1;
      bundle_cnt_d = bundle_cnt_q + BW'(1);
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
      if (accept_c && word_legal_c) begin
        acc_d[0] = in_instr;
        cnt_d    = CW'(1);
      end
    end else if (accept_c && word_legal_c) begin
      acc_d[cnt_q[1:0]] = in_instr;
      cnt_d             = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      ob_q         <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      illegal_q    <= 1'b0;
      bundle_cnt_q <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ob_q         <= ob_d;
      out_valid_q  <= out_valid_d;
      flush_pend_q <= flush_pend_d;
      illegal_q    <= illegal_d;
      bundle_cnt_q <= bundle_cnt_d;
    end
  end

`ifdef BUNDLE_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 8;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // Counts idle cycles while a partial bundle waits; saturates at the limit
  always_comb begin
    idle_d = idle_q;
    if (accept_c || do_close_c) begin
      idle_d = '0;
    end else if (cnt_nz_c && (idle_q != IDLE_W'(TIMEOUT_CYC))) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign timeout_c = cnt_nz_c && (idle_q == IDLE_W'(TIMEOUT_CYC));
`else
  assign timeout_c = 1'b0;
`endif

  assign out_valid  = out_valid_q;
  assign vliw_instr = ob_q;
  assign illegal    = illegal_q;
  assign bundle_cnt = bundle_cnt_q;
endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Scoreboard bench for vliw_bundle_packer: expected bundles are queued as stimulus is
// driven and compared against bundles taken from the output handshake.
module tb_vliw_bundle_packer;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_instr = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, illegal;
  logic [127:0] vliw_instr;
  logic [15:0]  bundle_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [127:0] exp_q[$];
  logic [127:0] obs_q[$];

  always #5 clk = ~clk;

  vliw_bundle_packer dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .vliw_instr(vliw_instr),
    .illegal(illegal), .bundle_cnt(bundle_cnt)
  );

  // Record each bundle that is handed over at the coming posedge
  always @(negedge clk) if (rstn && out_valid && out_ready) obs_q.push_back(vliw_instr);

  task automatic send(input logic [31:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_instr = w;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready=%0b required 1 for word %h", in_ready, w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = '0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic expect_bundle(input logic [127:0] b);
    exp_q.push_back(b);
    exp_cnt++;
  endtask

  task automatic wait_obs(input int n);
    int t = 0;
    while (obs_q.size() < n && t < 40) begin @(negedge clk); #1; t++; end
    if (obs_q.size() < n) begin
      n_cmp++; n_err++;
      $display("FAIL bundle_timeout: got %0d bundles required %0d", obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (vliw_instr !== '0) begin n_err++; $display("FAIL rst_vliw: got %h required 0", vliw_instr); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b required 0", illegal); end
    n_cmp++; if (bundle_cnt !== 16'd0) begin n_err++; $display("FAIL rst_bundle_cnt: got %0d required 0", bundle_cnt); end
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] got, want;
    send(32'h80001024); send(32'h8000102C); send(32'h80001034); send(32'h8000103C);
    expect_bundle(128'h8000103C_80001034_8000102C_80001024);
    send(32'h80000004); send(32'h8000000C); send(32'h80000014); send(32'h8000001C);
    expect_bundle(128'h8000001C_80000014_8000000C_80000004);
    wait_obs(exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL full_bundle: got %h required %h", got, want); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++; if (bundle_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL full_cnt: got %0d required %0d", bundle_cnt, exp_cnt); end
    @(negedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drop: out_valid got %b required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_raw();
    logic [127:0] got, want;
    send(32'h8000500C); send(32'h80007014); send(32'h80000458);
    expect_bundle(128'h00000000_00000000_80007014_8000500C);
    pulse_flush();
    expect_bundle(128'h00000000_00000000_00000000_80000458);
    wait_obs(exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL raw_bundle: got %h required %h", got, want); end
    end
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_waw();
    logic [127:0] got, want;
    send(32'h8000500C); send(32'h8000700C);
    expect_bundle(128'h00000000_00000000_00000000_8000500C);
    pulse_flush();
    expect_bundle(128'h00000000_00000000_00000000_8000700C);
    wait_obs(exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL waw_bundle: got %h required %h", got, want); end
    end
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] got, want;
    logic [127:0] a;
    a = 128'h8000103C_80001034_8000102C_80001024;
    out_ready = 1'b0;
    send(32'h80001024); send(32'h8000102C); send(32'h80001034); send(32'h8000103C);
    expect_bundle(a);
    send(32'h80000004); send(32'h8000000C); send(32'h80000014); send(32'h8000001C);
    expect_bundle(128'h8000001C_80000014_8000000C_80000004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b required 1", out_valid); end
      n_cmp++; if (vliw_instr !== a) begin n_err++; $display("FAIL bp_stable: got %h required %h", vliw_instr, a); end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_obs(exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL bp_bundle: got %h required %h", got, want); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++; if (bundle_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL bp_cnt: got %0d required %0d", bundle_cnt, exp_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_drops();
    logic [127:0] got, want;
    send(32'h8000500C);
    send(32'h80000003);
    n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL illegal_pulse: got %b required 1", illegal); end
    send(32'h0000500C);
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL illegal_clear: got %b required 0", illegal); end
    pulse_flush();
    expect_bundle(128'h00000000_00000000_00000000_8000500C);
    wait_obs(exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL drop_bundle: got %h required %h", got, want); end
    end
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_flush_same_cycle();
    logic [127:0] got, want;
    send(32'h8000500C);
    flush = 1'b1;
    send(32'h80007014);
    flush = 1'b0;
    expect_bundle(128'h00000000_00000000_00000000_8000500C);
    pulse_flush();
    expect_bundle(128'h00000000_00000000_00000000_80007014);
    wait_obs(exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL flush_bundle: got %h required %h", got, want); end
    end
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    logic [127:0] got, want;
    pulse_flush();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_flush: out_valid got %b required 0", out_valid); end
    @(posedge clk); #1;
    send(32'h8000500C);
    expect_bundle(128'h00000000_00000000_00000000_8000500C);
`ifndef BUNDLE_TIMEOUT_EN
    repeat (12) @(negedge clk);
    #1;
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL no_timeout: got %0d bundles required 0", obs_q.size()); end
    pulse_flush();
`endif
    wait_obs(exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL timeout_bundle: got %h required %h", got, want); end
    end
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fill();
    logic [127:0] got, want;
    out_ready = 1'b0;
    send(32'h80001024); send(32'h8000102C); send(32'h80001034); send(32'h8000103C);
    send(32'h80000004); send(32'h8000000C);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pending: out_valid got %b required 1", out_valid); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
    n_cmp++; if (vliw_instr !== '0) begin n_err++; $display("FAIL mid_rst_vliw: got %h required 0", vliw_instr); end
    n_cmp++; if (bundle_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d required 0", bundle_cnt); end
    exp_q.delete(); obs_q.delete(); exp_cnt = 0;
    out_ready = 1'b1;
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    send(32'h8000500C);
    pulse_flush();
    expect_bundle(128'h00000000_00000000_00000000_8000500C);
    wait_obs(exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL mid_rst_bundle: got %h required %h", got, want); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++; if (bundle_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL mid_rst_after_cnt: got %0d required %0d", bundle_cnt, exp_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_raw();
    test_waw();
    test_backpressure();
    test_drops();
    test_flush_same_cycle();
    test_timeout();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
